// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: holds the PC, fetches words over a req/ack memory port
// and presents instr/pc_plus4 to decode. Optional macro FETCH_STALL_CNT_EN adds stall_cycles.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        instr_valid
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] instr_next, pc_plus4_next;
  logic        valid_next;
  logic [31:0] redirect_aligned;

  assign redirect_aligned = {redirect_pc[31:2], 2'b00};
  assign imem_req         = (state == FETCH);
  assign imem_addr        = pc;

  // Next-state logic; a redirect always beats an ack or a stall.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    instr_next    = instr;
    pc_plus4_next = pc_plus4;
    valid_next    = instr_valid;
    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        if (redirect) begin
          pc_next = redirect_aligned;
        end else if (imem_ack) begin
          instr_next    = imem_rdata;
          pc_plus4_next = pc + 32'd4;
          valid_next    = 1'b1;
          state_next    = VALID;
        end
      end
      VALID: begin
        if (redirect) begin
          pc_next    = redirect_aligned;
          valid_next = 1'b0;
          state_next = FETCH;
        end else if (!stall) begin
          pc_next    = pc + 32'd4;
          valid_next = 1'b0;
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= {RESET_PC[31:2], 2'b00};
      instr       <= 32'd0;
      pc_plus4    <= 32'd0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instr       <= instr_next;
      pc_plus4    <= pc_plus4_next;
      instr_valid <= valid_next;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  // Counts cycles where decode held a valid instruction back.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cycles <= 32'd0;
    end else if (state == VALID && stall && !redirect) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed self-checking bench for instr_fetch_stage; inputs change and outputs
// are sampled on the falling edge, away from the active rising edge.
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] pc_plus4;
  logic        instr_valid;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  // Drive one cycle of inputs, let the rising edge act, return on the falling edge.
  task automatic applyStimulus(input logic rn, input logic ack, input logic [31:0] rdata,
                               input logic stl, input logic rdr, input logic [31:0] rpc);
    reset_n     = rn;
    imem_ack    = ack;
    imem_rdata  = rdata;
    stall       = stl;
    redirect    = rdr;
    redirect_pc = rpc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    reset_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    @(negedge clk);

    // Reset held two cycles with a stray ack present
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
    checkOutput("rst_pc4", pc_plus4, 32'h0);
`ifdef FETCH_STALL_CNT_EN
    checkOutput("rst_stallcnt", stall_cycles, 32'd0);
`endif

    // Release; stall/redirect in IDLE must not matter
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0080);
    checkOutput("rel_req", {31'd0, imem_req}, 32'd1);
    checkOutput("rel_addr", imem_addr, 32'h0);

    // Back-to-back fetch with immediate ack
    applyStimulus(1'b1, 1'b1, 32'h2008_0005, 1'b0, 1'b0, 32'h0);
    checkOutput("seq0_instr", instr, 32'h2008_0005);
    checkOutput("seq0_pc4", pc_plus4, 32'h4);
    checkOutput("seq0_valid", {31'd0, instr_valid}, 32'd1);
    checkOutput("seq0_req", {31'd0, imem_req}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("seq1_addr", imem_addr, 32'h4);
    checkOutput("seq1_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("seq1_keep", instr, 32'h2008_0005);
    applyStimulus(1'b1, 1'b1, 32'h2009_FFFC, 1'b0, 1'b0, 32'h0);
    checkOutput("seq1_instr", instr, 32'h2009_FFFC);
    checkOutput("seq1_pc4", pc_plus4, 32'h8);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("ws_addr0", imem_addr, 32'h8);

    // Three wait states; stall asserted during FETCH has no effect
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOutput("ws_req", {31'd0, imem_req}, 32'd1);
      checkOutput("ws_addr", imem_addr, 32'h8);
      checkOutput("ws_valid", {31'd0, instr_valid}, 32'd0);
    end
    applyStimulus(1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    checkOutput("ws_instr", instr, 32'h1234_5678);
    checkOutput("ws_pc4", pc_plus4, 32'hC);
    checkOutput("ws_valid_after", {31'd0, instr_valid}, 32'd1);

    // Five stall cycles in VALID
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
      checkOutput("stl_instr", instr, 32'h1234_5678);
      checkOutput("stl_pc4", pc_plus4, 32'hC);
      checkOutput("stl_valid", {31'd0, instr_valid}, 32'd1);
      checkOutput("stl_req", {31'd0, imem_req}, 32'd0);
    end
`ifdef FETCH_STALL_CNT_EN
    checkOutput("stl_cnt", stall_cycles, 32'd5);
`endif
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("stl_next_addr", imem_addr, 32'hC);

    // Redirect during FETCH drops the same-cycle ack
    applyStimulus(1'b1, 1'b1, 32'hBAD0_0000, 1'b0, 1'b1, 32'h0000_0043);
    checkOutput("rdf_addr", imem_addr, 32'h40);
    checkOutput("rdf_req", {31'd0, imem_req}, 32'd1);
    checkOutput("rdf_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("rdf_instr", instr, 32'h1234_5678);
    applyStimulus(1'b1, 1'b1, 32'hAAAA_5555, 1'b0, 1'b0, 32'h0);
    checkOutput("rdf_new_instr", instr, 32'hAAAA_5555);
    checkOutput("rdf_new_pc4", pc_plus4, 32'h44);

    // Redirect beats stall in VALID
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0102);
    checkOutput("rdv_addr", imem_addr, 32'h100);
    checkOutput("rdv_req", {31'd0, imem_req}, 32'd1);
    checkOutput("rdv_valid", {31'd0, instr_valid}, 32'd0);
`ifdef FETCH_STALL_CNT_EN
    checkOutput("rdv_cnt", stall_cycles, 32'd5);
`endif

    // Reset mid-FETCH with ack pending
    applyStimulus(1'b0, 1'b1, 32'h5555_5555, 1'b0, 1'b0, 32'h0);
    checkOutput("mrst_req", {31'd0, imem_req}, 32'd0);
    checkOutput("mrst_addr", imem_addr, 32'h0);
    checkOutput("mrst_instr", instr, 32'h0);
    checkOutput("mrst_pc4", pc_plus4, 32'h0);
    checkOutput("mrst_valid", {31'd0, instr_valid}, 32'd0);
`ifdef FETCH_STALL_CNT_EN
    checkOutput("mrst_cnt", stall_cycles, 32'd0);
`endif

    // PC wraps from the top of the address space
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_addr0", imem_addr, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    checkOutput("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_pc4", pc_plus4, 32'h0);
    checkOutput("wrap_instr", instr, 32'h0000_0001);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_addr", imem_addr, 32'h0);
    checkOutput("wrap_req", {31'd0, imem_req}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
